// File: rtl/boot_loader.sv
//======================================================================
// Module   : boot_loader
// Purpose  : Loads a framed, checksummed word stream into a 256x16 memory,
//            then hands the memory bus to the CPU and releases its hold.
// Revision : 1.0
//======================================================================
`default_nettype none

module boot_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] cpu_MAR,
    input  logic [DATA_W-1:0] cpu_data_out,
    input  logic              cpu_EN,
    input  logic              cpu_CS,
    output logic [ADDR_W-1:0] MAR,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              Mem_EN,
    output logic              Mem_CS,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HEADER = 3'd1,
        S_DATA   = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_last;

    logic              r_in_ready;
    logic              r_hold;
    logic              r_done;
    logic              r_error;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] r_sum;
    logic [ADDR_W:0]   r_idx;    // one bit wider so N=256 terminates without aliasing
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_count;  // N-1 as carried in the header

    assign w_accept = in_valid & r_in_ready;
    assign w_last   = (r_idx == {1'b0, r_count});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_HEADER;
            S_HEADER: if (w_accept) w_next = S_DATA;
            S_DATA:   if (w_accept && w_last) w_next = S_CHECK;
            S_CHECK:  if (w_accept) w_next = (in_data == r_sum) ? S_DONE : S_ERROR;
            S_DONE:   w_next = S_DONE;
            S_ERROR:  if (start) w_next = S_HEADER;
            default:  w_next = S_IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_in_ready <= 1'b0;
            r_hold     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_sum      <= '0;
            r_idx      <= '0;
            r_base     <= '0;
            r_count    <= '0;
        end else begin
            r_in_ready <= (w_next == S_HEADER) || (w_next == S_DATA) || (w_next == S_CHECK);
            r_hold     <= (w_next != S_DONE);
            r_done     <= (w_next == S_DONE);
            r_error    <= (w_next == S_ERROR);
            r_wr_en    <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_HEADER: begin
                        r_base  <= in_data[DATA_W-1 -: ADDR_W];
                        r_count <= in_data[ADDR_W-1:0];
                        r_sum   <= '0;
                        r_idx   <= '0;
                    end
                    S_DATA: begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_base + r_idx[ADDR_W-1:0];
                        r_wr_data <= in_data;
                        r_sum     <= r_sum + in_data;
                        r_idx     <= r_idx + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        MAR         = r_wr_addr;
        mem_data_in = r_wr_data;
        Mem_EN      = r_wr_en;
        Mem_CS      = r_wr_en;
        if (r_state == S_DONE) begin
            MAR         = cpu_MAR;
            mem_data_in = cpu_data_out;
            Mem_EN      = cpu_EN;
            Mem_CS      = cpu_CS;
        end
    end

    assign in_ready   = r_in_ready;
    assign cpu_hold   = r_hold;
    assign load_done  = r_done;
    assign load_error = r_error;

endmodule

`default_nettype wire

// File: tb/tb_boot_loader.sv
//======================================================================
// Module   : tb_boot_loader
// Purpose  : Directed self-checking bench for boot_loader with a 256x16
//            memory model on the memory port.
// Revision : 1.0
//======================================================================
`default_nettype none

module tb_boot_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  cpu_MAR = '0;
    logic [15:0] cpu_data_out = '0;
    logic        cpu_EN = 1'b0;
    logic        cpu_CS = 1'b0;
    logic [7:0]  MAR;
    logic [15:0] mem_data_in;
    logic        Mem_EN;
    logic        Mem_CS;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [256] = '{default: 16'h0000};
    int          wr_cnt = 0;

    boot_loader #(.ADDR_W(8), .DATA_W(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .cpu_MAR      (cpu_MAR),
        .cpu_data_out (cpu_data_out),
        .cpu_EN       (cpu_EN),
        .cpu_CS       (cpu_CS),
        .MAR          (MAR),
        .mem_data_in  (mem_data_in),
        .Mem_EN       (Mem_EN),
        .Mem_CS       (Mem_CS),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_error   (load_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (Mem_CS && Mem_EN) begin
            mem[MAR] <= mem_data_in;
            wr_cnt   <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Present a word and return #1 after the edge that consumed it.
    task automatic xfer(input logic [15:0] w);
        int n;
        n        = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("accept_wait", (n < 20), 1);
        step();
    endtask

    initial begin
        int base_cnt;
        int bad;

        // ---------------- reset values
        repeat (2) step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cpu_hold", cpu_hold, 1);
        chk("rst_load_done", load_done, 0);
        chk("rst_load_error", load_error, 0);
        chk("rst_mem_cs", Mem_CS, 0);
        chk("rst_mem_en", Mem_EN, 0);
        chk("rst_mar", MAR, 0);
        chk("rst_mem_data", mem_data_in, 0);
        reset = 1'b0;
        step();
        chk("idle_in_ready", in_ready, 0);

        // ---------------- basic load, back-to-back
        pulse_start();
        chk("hdr_in_ready", in_ready, 1);
        xfer(16'h1003);
        chk("hdr_no_write", Mem_CS, 0);
        xfer(16'h0001);
        chk("b_w0_cs", Mem_CS, 1);
        chk("b_w0_en", Mem_EN, 1);
        chk("b_w0_addr", MAR, 8'h10);
        chk("b_w0_data", mem_data_in, 16'h0001);
        xfer(16'h0002);
        chk("b_w1_addr", MAR, 8'h11);
        chk("b_w1_cs", Mem_CS, 1);
        xfer(16'h0003);
        chk("b_w2_addr", MAR, 8'h12);
        xfer(16'h0004);
        chk("b_w3_addr", MAR, 8'h13);
        chk("b_w3_data", mem_data_in, 16'h0004);
        chk("b_hold_before", cpu_hold, 1);
        xfer(16'h000A);
        in_valid = 1'b0;
        chk("b_done", load_done, 1);
        chk("b_hold", cpu_hold, 0);
        chk("b_err", load_error, 0);
        chk("b_in_ready", in_ready, 0);
        chk("b_mem13", mem[8'h13], 16'h0004);
        cpu_MAR = 8'h12;
        cpu_CS  = 1'b1;
        #1;
        chk("b_pass_mar", MAR, 8'h12);
        chk("b_cpu_read", mem[MAR], 16'h0003);
        chk("b_pass_cs", Mem_CS, 1);
        cpu_CS = 1'b0;
        pulse_start();
        chk("done_ignores_start", load_done, 1);
        chk("done_ignores_start_rdy", in_ready, 0);

        // ---------------- wrap and throttling
        pulse_reset();
        chk("rst2_done", load_done, 0);
        chk("rst2_hold", cpu_hold, 1);
        pulse_start();
        xfer(16'hFE02);
        xfer(16'hAAAA);
        chk("w_w0_addr", MAR, 8'hFE);
        chk("w_w0_cs", Mem_CS, 1);
        in_valid = 1'b0;
        step();
        chk("w_stall_cs", Mem_CS, 0);
        chk("w_stall_rdy", in_ready, 1);
        repeat (2) step();
        xfer(16'h5555);
        chk("w_w1_addr", MAR, 8'hFF);
        in_valid = 1'b0;
        repeat (3) step();
        xfer(16'h1111);
        chk("w_w2_addr", MAR, 8'h00);
        chk("w_w2_data", mem_data_in, 16'h1111);
        in_valid = 1'b0;
        repeat (3) step();
        chk("w_no_early_done", load_done, 0);
        xfer(16'h1110);
        in_valid = 1'b0;
        chk("w_done", load_done, 1);
        chk("w_memFE", mem[8'hFE], 16'hAAAA);
        chk("w_memFF", mem[8'hFF], 16'h5555);
        chk("w_mem00", mem[8'h00], 16'h1111);

        // ---------------- bad checksum, then recovery
        pulse_reset();
        pulse_start();
        xfer(16'h0000);
        xfer(16'h1234);
        xfer(16'h1235);
        in_valid = 1'b0;
        chk("e_error", load_error, 1);
        chk("e_done", load_done, 0);
        chk("e_hold", cpu_hold, 1);
        chk("e_cs", Mem_CS, 0);
        chk("e_rdy", in_ready, 0);
        chk("e_mem00", mem[8'h00], 16'h1234);
        base_cnt     = wr_cnt;
        cpu_MAR      = 8'h00;
        cpu_data_out = 16'hDEAD;
        cpu_CS       = 1'b1;
        cpu_EN       = 1'b1;
        #1;
        chk("e_cpu_blocked_cs", Mem_CS, 0);
        repeat (2) step();
        cpu_CS = 1'b0;
        cpu_EN = 1'b0;
        chk("e_no_cpu_write", wr_cnt - base_cnt, 0);
        chk("e_mem00_kept", mem[8'h00], 16'h1234);
        pulse_start();
        chk("e_restart_err", load_error, 0);
        chk("e_restart_rdy", in_ready, 1);
        xfer(16'h0000);
        xfer(16'h4321);
        xfer(16'h4321);
        in_valid = 1'b0;
        chk("e_recover_done", load_done, 1);
        chk("e_recover_err", load_error, 0);
        chk("e_recover_mem", mem[8'h00], 16'h4321);

        // ---------------- full memory, N=256
        pulse_reset();
        pulse_start();
        xfer(16'h00FF);
        base_cnt = wr_cnt;
        for (int k = 0; k < 256; k++) begin
            xfer(k[15:0]);
        end
        chk("f_not_done_early", load_done, 0);
        xfer(16'h7F80);
        in_valid = 1'b0;
        chk("f_done", load_done, 1);
        chk("f_err", load_error, 0);
        chk("f_write_count", wr_cnt - base_cnt, 256);
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            if (mem[k] !== k[15:0]) bad++;
        end
        chk("f_mem_bad_words", bad, 0);

        // ---------------- reset mid-load
        pulse_reset();
        pulse_start();
        xfer(16'h2003);
        xfer(16'hBEEF);
        chk("r_w0_cs", Mem_CS, 1);
        in_data = 16'hCAFE;
        reset   = 1'b1;
        step();
        in_valid = 1'b0;
        chk("r_cs_after_rst", Mem_CS, 0);
        chk("r_en_after_rst", Mem_EN, 0);
        chk("r_mar_after_rst", MAR, 0);
        chk("r_data_after_rst", mem_data_in, 0);
        chk("r_rdy_after_rst", in_ready, 0);
        chk("r_hold_after_rst", cpu_hold, 1);
        chk("r_first_kept", mem[8'h20], 16'hBEEF);
        chk("r_second_dropped", mem[8'h21], 16'h0021);
        reset = 1'b0;
        repeat (3) step();
        chk("r_idle_rdy", in_ready, 0);

        // start coincident with reset: reset wins
        start = 1'b1;
        reset = 1'b1;
        step();
        start = 1'b0;
        reset = 1'b0;
        step();
        chk("rs_rdy", in_ready, 0);
        pulse_start();
        chk("rs_start_after", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
